// File: rtl/errchk_pkg.sv
// Shared types and helpers for the OBC challenge-response watchdog.
// Holds the FSM state encoding, the question width and the reference answer function.
package errchk_pkg;

    localparam int Q_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
        DECIDE   = 3'd3,
        SHUTDOWN = 3'd4
    } state_t;

    // Answer a healthy OBC must return for question q.
    function automatic logic [Q_W-1:0] expected_answer(input logic [Q_W-1:0] q);
        return {q[2] ^ q[3], q[1] ^ q[2], q[0] ^ q[1], ~q[0]};
    endfunction

endpackage

// File: rtl/errchk_qgen.sv
// Question generator: 4-bit maximal-length LFSR (period 15, never zero).
// Loads SEED on reset and steps only when advance is high.
module errchk_qgen
    import errchk_pkg::*;
#(
    parameter logic [Q_W-1:0] SEED = 4'b0001
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           advance,
    output logic [Q_W-1:0] lfsr
);

    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (advance) begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

endmodule

// File: rtl/obc_challenge_sequencer.sv
// Challenge-response watchdog: runs periodic question sessions against the OBC and
// hands control to OBC2 (override + one obc_reset pulse) after too many failed sessions.
module obc_challenge_sequencer
    import errchk_pkg::*;
#(
    parameter int             ROUNDS    = 10,
    parameter int             PASS_MIN  = 10,
    parameter int             TIMEOUT   = 15,
    parameter int             PERIOD    = 100,
    parameter int             MAX_FAILS = 3,
    parameter logic [Q_W-1:0] SEED      = 4'b0001
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [Q_W-1:0]                question,
    output logic                          q_valid,
    input  logic [Q_W-1:0]                answer_obc,
    input  logic                          ans_valid,
    output logic                          busy,
    output logic                          session_pass,
    output logic [$clog2(ROUNDS+1)-1:0]   correct_cnt,
    output logic                          override,
    output logic                          obc_reset
);

    localparam int CNT_W  = $clog2(ROUNDS + 1);
    localparam int GAP_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TIM_W  = $clog2(TIMEOUT);
    localparam int RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int FAIL_W = (MAX_FAILS > 1) ? $clog2(MAX_FAILS) : 1;

    state_t            state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TIM_W-1:0]  timer;
    logic [RND_W-1:0]  round;
    logic [FAIL_W-1:0] fail_cnt;
    logic [Q_W-1:0]    lfsr;

    // The LFSR steps during ISSUE, so the value latched on entry to ISSUE is this round's question.
    errchk_qgen #(.SEED(SEED)) u_qgen (
        .clk     (clk),
        .reset   (reset),
        .advance (state == ISSUE),
        .lfsr    (lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            timer        <= '0;
            round        <= '0;
            fail_cnt     <= '0;
            question     <= '0;
            q_valid      <= 1'b0;
            busy         <= 1'b0;
            session_pass <= 1'b0;
            correct_cnt  <= '0;
            override     <= 1'b0;
            obc_reset    <= 1'b0;
        end else begin
            q_valid      <= 1'b0;
            session_pass <= 1'b0;
            obc_reset    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (gap_cnt == GAP_W'(PERIOD - 1)) begin
                        gap_cnt     <= '0;
                        round       <= '0;
                        correct_cnt <= '0;
                        busy        <= 1'b1;
                        question    <= lfsr;
                        q_valid     <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    timer <= timer + TIM_W'(1);
                    // An answer arriving on the expiry cycle is still judged on its merits.
                    if (ans_valid || timer == TIM_W'(TIMEOUT - 1)) begin
                        if (ans_valid && answer_obc == expected_answer(question)) begin
                            correct_cnt <= correct_cnt + CNT_W'(1);
                        end
                        round <= round + RND_W'(1);
                        if (round == RND_W'(ROUNDS - 1)) begin
                            state <= DECIDE;
                        end else begin
                            question <= lfsr;
                            q_valid  <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end

                DECIDE: begin
                    busy <= 1'b0;
                    if (correct_cnt >= CNT_W'(PASS_MIN)) begin
                        session_pass <= 1'b1;
                        fail_cnt     <= '0;
                        state        <= IDLE;
                    end else begin
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                        if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                            override  <= 1'b1;
                            obc_reset <= 1'b1;
                            state     <= SHUTDOWN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                SHUTDOWN: begin
                    state <= SHUTDOWN;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obc_challenge_sequencer.sv
// Directed bench for obc_challenge_sequencer with PERIOD=4 and default session parameters.
// Question/answer tables below are hand-derived from the LFSR recurrence and answer formula.
module tb_obc_challenge_sequencer;

    localparam int ROUNDS    = 10;
    localparam int PASS_MIN  = 10;
    localparam int TIMEOUT   = 15;
    localparam int PERIOD    = 4;
    localparam int MAX_FAILS = 3;

    localparam int M_NOW    = 0;  // correct answer in the first WAIT cycle
    localparam int M_WRONG  = 1;  // wrong answer in the first WAIT cycle
    localparam int M_NONE   = 2;  // never answer
    localparam int M_EXPIRY = 3;  // correct answer exactly on the timeout cycle
    localparam int M_ISSUE  = 4;  // correct answer only during ISSUE, then silence

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] question;
    logic       q_valid;
    logic [3:0] answer_obc;
    logic       ans_valid;
    logic       busy;
    logic       session_pass;
    logic [3:0] correct_cnt;
    logic       override;
    logic       obc_reset;

    int n_checks = 0;
    int n_pass   = 0;
    int q_idx    = 0;
    int round_mode [ROUNDS];

    logic [3:0] q_tab [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                               4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                               4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [3:0] a_tab [15] = '{4'b0010, 4'b0111, 4'b1101, 4'b1010, 4'b0100,
                               4'b1011, 4'b0110, 4'b1111, 4'b1110, 4'b1100,
                               4'b1000, 4'b0000, 4'b0011, 4'b0101, 4'b1001};

    obc_challenge_sequencer #(
        .ROUNDS    (ROUNDS),
        .PASS_MIN  (PASS_MIN),
        .TIMEOUT   (TIMEOUT),
        .PERIOD    (PERIOD),
        .MAX_FAILS (MAX_FAILS),
        .SEED      (4'b0001)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .question     (question),
        .q_valid      (q_valid),
        .answer_obc   (answer_obc),
        .ans_valid    (ans_valid),
        .busy         (busy),
        .session_pass (session_pass),
        .correct_cnt  (correct_cnt),
        .override     (override),
        .obc_reset    (obc_reset)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Advances at least one cycle; returns the number of negedges until q_valid, or -1.
    task automatic wait_qvalid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (q_valid === 1'b1) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic run_session(input bit at_issue, input int n_rounds, input int exp_correct,
                               input bit exp_pass, input bit exp_shut);
        int         cnt;
        int         cyc;
        int         k;
        int         mode;
        logic [3:0] exp_q;
        logic [3:0] cur_ans;
        cnt = 0;
        for (int r = 0; r < n_rounds; r++) begin
            if (r == 0 && !at_issue) begin
                wait_qvalid(cyc);
                n_checks++;
                if (cyc < 0) begin
                    $display("FAIL session_start: q_valid not seen within 200 cycles");
                    return;
                end else n_pass++;
            end
            exp_q   = q_tab[q_idx];
            cur_ans = a_tab[q_idx];
            q_idx   = (q_idx + 1) % 15;
            n_checks++;
            if (question !== exp_q)
                $display("FAIL question r%0d: got %b want %b", r, question, exp_q);
            else n_pass++;
            if (r == 0) begin
                n_checks++;
                if (busy !== 1'b1 || correct_cnt !== 4'd0)
                    $display("FAIL session_open: busy=%b cnt=%0d want busy=1 cnt=0", busy, correct_cnt);
                else n_pass++;
            end
            mode = round_mode[r];
            k = (mode == M_NOW || mode == M_WRONG) ? 0 : (mode == M_EXPIRY) ? TIMEOUT - 1 : -1;
            if (mode == M_ISSUE) begin
                ans_valid  = 1'b1;
                answer_obc = cur_ans;
            end
            @(negedge clk);
            ans_valid = 1'b0;
            for (int w = 0; w < TIMEOUT; w++) begin
                if (w == k) begin
                    ans_valid  = 1'b1;
                    answer_obc = (mode == M_WRONG) ? ~cur_ans : cur_ans;
                end
                @(negedge clk);
                ans_valid = 1'b0;
                if (w == k || w == TIMEOUT - 1) break;
                n_checks++;
                if (q_valid !== 1'b0 || question !== exp_q)
                    $display("FAIL wait_hold r%0d w%0d: q_valid=%b q=%b want 0/%b", r, w, q_valid, question, exp_q);
                else n_pass++;
            end
            if (mode == M_NOW || mode == M_EXPIRY) cnt++;
            n_checks++;
            if (correct_cnt !== 4'(cnt))
                $display("FAIL correct_cnt r%0d: got %0d want %0d", r, correct_cnt, cnt);
            else n_pass++;
            if (r < ROUNDS - 1) begin
                n_checks++;
                if (q_valid !== 1'b1)
                    $display("FAIL round_close r%0d: q_valid got %b want 1", r, q_valid);
                else n_pass++;
            end else begin
                n_checks++;
                if (q_valid !== 1'b0 || busy !== 1'b1 || correct_cnt !== 4'(exp_correct))
                    $display("FAIL decide: q_valid=%b busy=%b cnt=%0d want 0/1/%0d",
                             q_valid, busy, correct_cnt, exp_correct);
                else n_pass++;
                @(negedge clk);
                n_checks++;
                if (session_pass !== exp_pass || obc_reset !== exp_shut || override !== exp_shut
                    || busy !== 1'b0 || correct_cnt !== 4'(exp_correct))
                    $display("FAIL verdict: pass=%b rst=%b ovr=%b busy=%b cnt=%0d want %b/%b/%b/0/%0d",
                             session_pass, obc_reset, override, busy, correct_cnt,
                             exp_pass, exp_shut, exp_shut, exp_correct);
                else n_pass++;
                if (!exp_shut) begin
                    @(negedge clk);
                    n_checks++;
                    if (session_pass !== 1'b0 || correct_cnt !== 4'(exp_correct))
                        $display("FAIL idle_hold: pass=%b cnt=%0d want 0/%0d", session_pass, correct_cnt, exp_correct);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset;
        ans_valid  = 1'b0;
        answer_obc = 4'b0000;
        reset      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({question, q_valid, busy, session_pass, correct_cnt, override, obc_reset} !== 13'd0)
            $display("FAIL reset_outputs: q=%b qv=%b busy=%b pass=%b cnt=%0d ovr=%b rst=%b want all 0",
                     question, q_valid, busy, session_pass, correct_cnt, override, obc_reset);
        else n_pass++;
        q_idx = 0;
    endtask

    task automatic test_first_question;
        int cyc;
        reset = 1'b0;
        wait_qvalid(cyc);
        n_checks++;
        if (cyc !== PERIOD)
            $display("FAIL first_qvalid_cycle: got %0d want %0d", cyc, PERIOD);
        else n_pass++;
    endtask

    task automatic test_pass_session;
        for (int r = 0; r < ROUNDS; r++) round_mode[r] = M_NOW;
        run_session(1'b1, ROUNDS, 10, 1'b1, 1'b0);
    endtask

    task automatic test_timeout_session;
        for (int r = 0; r < ROUNDS; r++) round_mode[r] = M_NONE;
        run_session(1'b0, ROUNDS, 0, 1'b0, 1'b0);
        n_checks++;
        if (override !== 1'b0)
            $display("FAIL override_after_fail1: got %b want 0", override);
        else n_pass++;
    endtask

    task automatic test_expiry_and_issue;
        for (int r = 0; r < ROUNDS; r++) round_mode[r] = M_NOW;
        round_mode[0] = M_EXPIRY;
        round_mode[1] = M_ISSUE;
        round_mode[2] = M_WRONG;
        run_session(1'b0, ROUNDS, 8, 1'b0, 1'b0);
    endtask

    task automatic test_shutdown;
        int bad_rst;
        int bad_ovr;
        int bad_qv;
        for (int r = 0; r < ROUNDS; r++) round_mode[r] = M_WRONG;
        run_session(1'b0, ROUNDS, 0, 1'b0, 1'b1);
        bad_rst = 0;
        bad_ovr = 0;
        bad_qv  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (obc_reset !== 1'b0) bad_rst++;
            if (override !== 1'b1) bad_ovr++;
            if (q_valid !== 1'b0 || busy !== 1'b0) bad_qv++;
        end
        n_checks++;
        if (bad_rst != 0) $display("FAIL obc_reset_single: extra cycles high got %0d want 0", bad_rst);
        else n_pass++;
        n_checks++;
        if (bad_ovr != 0) $display("FAIL override_sticky: cycles low got %0d want 0", bad_ovr);
        else n_pass++;
        n_checks++;
        if (bad_qv != 0) $display("FAIL shutdown_quiet: active cycles got %0d want 0", bad_qv);
        else n_pass++;
    endtask

    task automatic test_reset_mid_session;
        int cyc;
        test_reset;
        test_first_question;
        for (int r = 0; r < ROUNDS; r++) round_mode[r] = M_NOW;
        run_session(1'b1, 5, 0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({question, q_valid, busy, session_pass, correct_cnt, override, obc_reset} !== 13'd0)
            $display("FAIL mid_reset_outputs: q=%b qv=%b busy=%b pass=%b cnt=%0d ovr=%b rst=%b want all 0",
                     question, q_valid, busy, session_pass, correct_cnt, override, obc_reset);
        else n_pass++;
        reset = 1'b0;
        q_idx = 0;
        wait_qvalid(cyc);
        n_checks++;
        if (cyc !== PERIOD || question !== 4'b0001)
            $display("FAIL restart_question: cycle %0d q=%b want %0d/0001", cyc, question, PERIOD);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_first_question;
        test_pass_session;
        test_timeout_session;
        test_expiry_and_issue;
        test_shutdown;
        test_reset_mid_session;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
